// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

    // Native word width of the fetch datapath.
    localparam int          XLEN_DEF = 32;
    // Instruction shown to decode when the buffer is empty (addi x0,x0,0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_STEP  = 32'h0000_0004;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs between fetch and decode.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == CNT_W'(0));
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A flush overrides both ports; a push into a full buffer is only taken alongside a pop.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    // Storage write plus pointer and occupancy update; flush empties the buffer in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= PTR_W'(0);
            r_rptr  <= PTR_W'(0);
            r_count <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_flush) begin
            r_wptr  <= PTR_W'(0);
            r_rptr  <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    fetch_fifo_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .i_push (i_push && !i_flush),
        .i_pop  (w_do_pop),
        .i_full (o_full)
    );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Property checker for the fetch instruction buffer.
module fetch_fifo_chk (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_full
);

    // The credit scheme must never push into a full buffer unless the head leaves that cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) (i_push && i_full) |-> i_pop);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests, buffers
// returned words with their PCs and hands them to decode; redirects flush and restart.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          XLEN       = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_RESET = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] NOP      = XLEN'(NOP_INST);

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_next;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_outstanding_next;
    logic [CNT_W-1:0]  r_drop;
    logic [CNT_W-1:0]  w_drop_next;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic [2*XLEN-1:0] w_head;
    logic [CNT_W:0]    w_credit_used;
    logic [XLEN-1:0]   w_resp_pc;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    // Redirect wins: it suppresses the pop, the push and the request of its cycle.
    assign w_pop  = !w_empty && inst_ready && !redirect_valid;
    assign w_push = imem_resp_valid && (r_drop == CNT_W'(0)) && !redirect_valid;

    // Buffered words plus in-flight requests may not exceed the buffer size; a pop
    // in the same cycle already counts as a free slot.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding} - {{CNT_W{1'b0}}, w_pop};
    assign w_req_valid   = !rst && !redirect_valid && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_accept      = w_req_valid && imem_req_ready;

    // With nothing left to drop, every in-flight request was issued from the current
    // PC stream, so the oldest one sits exactly 'outstanding' words behind the PC.
    assign w_resp_pc = r_pc - (XLEN'(r_outstanding) * STEP);

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = !w_empty;
    assign inst           = w_empty ? NOP : w_head[XLEN-1:0];
    assign inst_pc        = w_empty ? {XLEN{1'b0}} : w_head[2*XLEN-1:XLEN];

    // Target byte-offset bits are ignored; the buffer's full flag is implied by the credits.
    assign w_unused = &{1'b0, redirect_pc[1:0], w_full};

    // Next PC, in-flight count and pending-drop count.
    always_comb begin
        w_pc_next          = r_pc;
        w_outstanding_next = r_outstanding;
        w_drop_next        = r_drop;

        if (redirect_valid) begin
            w_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_accept) begin
            w_pc_next = r_pc + STEP;
        end else begin
            w_pc_next = r_pc;
        end

        case ({w_accept, imem_resp_valid})
            2'b10:   w_outstanding_next = r_outstanding + CNT_W'(1);
            2'b01:   w_outstanding_next = r_outstanding - CNT_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase

        if (redirect_valid) begin
            w_drop_next = r_outstanding - CNT_W'(imem_resp_valid);
        end else if (imem_resp_valid && (r_drop != CNT_W'(0))) begin
            w_drop_next = r_drop - CNT_W'(1);
        end else begin
            w_drop_next = r_drop;
        end
    end

    // PC and request bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= PC_RESET;
            r_outstanding <= CNT_W'(0);
            r_drop        <= CNT_W'(0);
        end else begin
            r_pc          <= w_pc_next;
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({w_resp_pc, imem_resp_data}),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table and sequences plus randomized
// traffic against a stream-level reference model and an in-order memory model.
module tb_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        d5_req_valid, d5_req_ready;
    logic [31:0] d5_req_addr;
    logic        d5_resp_valid;
    logic [31:0] d5_resp_data;
    logic        d5_redirect_valid;
    logic [31:0] d5_redirect_pc;
    logic        d5_inst_valid, d5_inst_ready;
    logic [31:0] d5_inst, d5_inst_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .XLEN(32)) dut5 (
        .clk(clk), .rst(rst),
        .imem_req_valid(d5_req_valid), .imem_req_ready(d5_req_ready), .imem_req_addr(d5_req_addr),
        .imem_resp_valid(d5_resp_valid), .imem_resp_data(d5_resp_data),
        .redirect_valid(d5_redirect_valid), .redirect_pc(d5_redirect_pc),
        .inst_valid(d5_inst_valid), .inst_ready(d5_inst_ready), .inst(d5_inst), .inst_pc(d5_inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc; } t1_vec_t;

    mreq_t       mq[$];
    logic [31:0] d5_pcs[$];
    t1_vec_t     t1_tab[6];
    int          cyc, lat, last_due, occ, n_vec, n_err;
    logic [31:0] exp_pc, exp_fetch;
    bit          prev_redirect, found;
    logic        v_inst_ready, v_req_ready, v_redirect;
    logic [31:0] v_redirect_pc;
    logic        o_rv, o_iv;
    logic [31:0] o_addr, o_inst, o_ipc;
    logic        d5_pend;
    logic [31:0] d5_pend_addr;

    // Contents of instruction memory at a word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        d5_pcs.delete();
        occ = 0;
        exp_pc = 32'h0;
        exp_fetch = 32'h0;
        last_due = -1;
        prev_redirect = 1'b0;
        d5_pend = 1'b0;
    endtask

    // One clock: drive at negedge, observe and check, advance the model, wait for posedge.
    task automatic cycle();
        bit    resp_now, pop_m, acc, exp_rv;
        mreq_t e;
        @(negedge clk);
        inst_ready     = v_inst_ready;
        imem_req_ready = v_req_ready;
        redirect_valid = v_redirect;
        redirect_pc    = v_redirect_pc;
        resp_now = 1'b0;
        imem_resp_data = 32'h0;
        if (!rst && mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                resp_now = 1'b1;
                imem_resp_data = memf(mq[0].addr);
            end
        end
        imem_resp_valid = resp_now;
        d5_resp_valid = d5_pend && !rst;
        d5_resp_data  = memf(d5_pend_addr);
        #1;
        o_rv = imem_req_valid; o_addr = imem_req_addr;
        o_iv = inst_valid; o_inst = inst; o_ipc = inst_pc;
        if (!rst) begin
            pop_m = (occ > 0) && v_inst_ready && !v_redirect;
            chk("inst_valid", 32'(o_iv), 32'(occ > 0));
            if (prev_redirect) chk("post_redirect_empty", 32'(o_iv), 32'd0);
            if (occ > 0) begin
                if (pop_m) begin
                    chk("stream_pc", o_ipc, exp_pc);
                    chk("stream_inst", o_inst, memf(exp_pc));
                end
            end else begin
                chk("idle_inst", o_inst, NOP);
                chk("idle_pc", o_ipc, 32'd0);
            end
            exp_rv = !v_redirect && ((occ - int'(pop_m) + mq.size()) < DEPTH);
            chk("req_valid", 32'(o_rv), 32'(exp_rv));
            if (o_rv) chk("req_addr", o_addr, exp_fetch);
            acc = o_rv && v_req_ready;
            if (resp_now) begin
                e = mq.pop_front();
                if (!e.stale && !v_redirect) occ++;
            end
            if (pop_m) begin
                occ--;
                exp_pc += 32'd4;
            end
            if (v_redirect) begin
                occ = 0;
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_pc = {v_redirect_pc[31:2], 2'b00};
                exp_fetch = exp_pc;
            end
            if (acc) begin
                e.addr = o_addr;
                e.due = cyc + lat;
                if (e.due <= last_due) e.due = last_due + 1;
                last_due = e.due;
                e.stale = 1'b0;
                mq.push_back(e);
                exp_fetch += 32'd4;
            end
            if (d5_inst_valid) begin
                chk("d5_inst", d5_inst, memf(d5_inst_pc));
                d5_pcs.push_back(d5_inst_pc);
            end
            d5_pend = d5_req_valid;
            d5_pend_addr = d5_req_addr;
        end else begin
            d5_pend = 1'b0;
        end
        prev_redirect = v_redirect && !rst;
        v_redirect = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle();
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_first_valid(input string name, input logic [31:0] exp);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (o_iv) begin
                found = 1'b1;
                chk(name, o_ipc, exp);
            end
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; lat = 1;
        rst = 1'b1;
        v_inst_ready = 1'b0; v_req_ready = 1'b0; v_redirect = 1'b0; v_redirect_pc = 32'h0;
        inst_ready = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        d5_req_ready = 1'b1; d5_inst_ready = 1'b1; d5_redirect_valid = 1'b0; d5_redirect_pc = 32'h0;
        d5_resp_valid = 1'b0; d5_resp_data = 32'h0; d5_pend_addr = 32'h0;
        model_reset();

        // T1 expectations per cycle after reset release: {req_valid, req_addr, inst_valid, inst_pc}
        t1_tab[0] = '{1'b1, 32'd0,  1'b0, 32'd0};
        t1_tab[1] = '{1'b1, 32'd4,  1'b0, 32'd0};
        t1_tab[2] = '{1'b1, 32'd8,  1'b1, 32'd0};
        t1_tab[3] = '{1'b1, 32'd12, 1'b1, 32'd4};
        t1_tab[4] = '{1'b1, 32'd16, 1'b1, 32'd8};
        t1_tab[5] = '{1'b1, 32'd20, 1'b1, 32'd12};

        // Reset state while rst is held
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_d5_addr", d5_req_addr, 32'hFFFF_FFF8);

        // T1: 1-cycle memory, decode always ready
        do_reset();
        v_inst_ready = 1'b1; v_req_ready = 1'b1; lat = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t1_req_valid", 32'(o_rv), 32'(t1_tab[i].rv));
            chk("t1_req_addr", o_addr, t1_tab[i].addr);
            chk("t1_inst_valid", 32'(o_iv), 32'(t1_tab[i].iv));
            chk("t1_inst_pc", o_ipc, t1_tab[i].ipc);
        end

        // T5: PC wrap on the second instance, which ran alongside T1
        chk("t5_count", 32'(d5_pcs.size() >= 3), 32'd1);
        if (d5_pcs.size() >= 3) begin
            chk("t5_pc0", d5_pcs[0], 32'hFFFF_FFF8);
            chk("t5_pc1", d5_pcs[1], 32'hFFFF_FFFC);
            chk("t5_pc2", d5_pcs[2], 32'h0000_0000);
        end

        // T2: decode stalls for 10 cycles, then resumes
        repeat (4) cycle();
        v_inst_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_req_stopped", 32'(o_rv), 32'd0);
        chk("t2_inst_held", 32'(o_iv), 32'd1);
        v_inst_ready = 1'b1;
        repeat (10) cycle();

        // T3: 3-cycle memory, redirect with two requests in flight
        do_reset();
        lat = 3; v_inst_ready = 1'b1; v_req_ready = 1'b1;
        repeat (2) cycle();
        v_redirect = 1'b1; v_redirect_pc = 32'h0000_0103;
        cycle();
        wait_first_valid("t3_first_pc", 32'h0000_0100);
        repeat (6) cycle();

        // T4: redirect coinciding with a response and a pop
        lat = 1;
        repeat (4) cycle();
        for (int k = 0; k < 20; k++) begin
            if (mq.size() > 0 && mq[0].due == cyc && occ > 0) break;
            cycle();
        end
        v_redirect = 1'b1; v_redirect_pc = 32'h0000_0200;
        cycle();
        cycle();
        chk("t4_flushed", 32'(o_iv), 32'd0);
        wait_first_valid("t4_first_pc", 32'h0000_0200);

        // Randomized traffic with varying latency, back-pressure and redirects
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) lat = $urandom_range(1, 4);
            v_inst_ready = ($urandom_range(0, 9) < 7);
            v_req_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                v_redirect = 1'b1;
                v_redirect_pc = $urandom;
            end
            cycle();
        end

        // T6: asynchronous reset with the buffer full
        lat = 1; v_req_ready = 1'b1; v_inst_ready = 1'b0;
        repeat (6) cycle();
        chk("t6_full_before", 32'(o_iv), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_req_addr", imem_req_addr, 32'd0);
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_inst", inst, NOP);
        chk("t6_inst_pc", inst_pc, 32'd0);
        chk("t6_d5_req_addr", d5_req_addr, 32'hFFFF_FFF8);
        repeat (2) cycle();
        #2 rst = 1'b0;
        model_reset();
        v_inst_ready = 1'b1;
        wait_first_valid("t6_restart_pc", 32'h0000_0000);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
